piano_keys: RTL and testbench

PIANO_KEYS -- requirements
Module: piano_keys

---
 rtl/piano_keys_pkg.sv | 22 ++
 rtl/piano_keys_debounce.sv | 51 +++++
 rtl/piano_keys.sv | 72 +++++++
 tb/tb_piano_keys.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/piano_keys_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piano_pkg: shared constants, key index type and priority encoder   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package piano_pkg;

  localparam int N_KEYS           = 3;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef logic [1:0] key_idx_t;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic key_idx_t lowest_idx(input logic [N_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = key_idx_t'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/piano_keys_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce: 2-flop synchronizer + stable-level counter, one key  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic key_o
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               key_q, key_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with key_q.
  always_comb begin
    key_d = key_q;
    cnt_d = '0;
    if (~sync2_q != key_q) begin
      if (cnt_q == c_cnt_last) key_d = ~key_q;
      else                     cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      key_q   <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  assign key_o = key_q;

endmodule
`default_nettype wire

// File: rtl/piano_keys.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piano_keys: debounced keys, priority tone select, press pulse.     |
// | Option PIANO_KEYS_HOLD_EN latches the last pressed tone. Rev 1.0   |
// +--------------------------------------------------------------------+
module piano_keys
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn,
  output logic [N_KEYS-1:0] key_state,
  output logic [1:0]        tone_sel,
  output logic              tone_en,
  output logic              key_press
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn[i]),
      .key_o   (key_state[i])
    );
  end

  logic [N_KEYS-1:0] key_prev_q;
  logic [N_KEYS-1:0] w_rise;
  key_idx_t          tone_sel_q, tone_sel_d;
  logic              tone_en_q, tone_en_d;
  logic              key_press_q, key_press_d;

  assign w_rise = key_state & ~key_prev_q;

  always_comb begin
    tone_sel_d  = tone_sel_q;
    tone_en_d   = tone_en_q;
    key_press_d = |w_rise;
`ifdef PIANO_KEYS_HOLD_EN
    // Only a new press moves the tone; releases are ignored.
    if (|w_rise) begin
      tone_sel_d = lowest_idx(w_rise);
      tone_en_d  = 1'b1;
    end
`else
    tone_en_d = |key_state;
    if (|key_state) tone_sel_d = lowest_idx(key_state);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q  <= '0;
      tone_sel_q  <= '0;
      tone_en_q   <= 1'b0;
      key_press_q <= 1'b0;
    end else begin
      key_prev_q  <= key_state;
      tone_sel_q  <= tone_sel_d;
      tone_en_q   <= tone_en_d;
      key_press_q <= key_press_d;
    end
  end

  assign tone_sel  = tone_sel_q;
  assign tone_en   = tone_en_q;
  assign key_press = key_press_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_keys.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_piano_keys: directed per-cycle vectors, DEBOUNCE_CYCLES=4       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_piano_keys;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [2:0] key_state;
  logic [1:0] tone_sel;
  logic       tone_en;
  logic       key_press;

  always #10 clk = ~clk;

  piano_keys #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .key_state (key_state),
    .tone_sel  (tone_sel),
    .tone_en   (tone_en),
    .key_press (key_press)
  );

  typedef struct {
    logic       r;
    logic [2:0] b;
    logic [2:0] ks;
    logic [1:0] sel;
    logic       en;
    logic       kp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic r, input logic [2:0] b, input logic [2:0] ks,
                     input logic [1:0] sel, input logic en, input logic kp);
    vec_t v;
    v.r = r; v.b = b; v.ks = ks; v.sel = sel; v.en = en; v.kp = kp;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [2:0] b);
    rst = r;
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] ks, input logic [1:0] sel,
                       input logic en, input logic kp);
    n_vec++;
    if (key_state !== ks || tone_sel !== sel || tone_en !== en || key_press !== kp) begin
      n_err++;
      $display("FAIL %s: got ks=%b sel=%0d en=%b kp=%b, want ks=%b sel=%0d en=%b kp=%b",
               name, key_state, tone_sel, tone_en, key_press, ks, sel, en, kp);
    end
  endtask

  int pulses;

  initial begin
`ifndef PIANO_KEYS_HOLD_EN
    // reset
    add(2, 1, 3'b111, 3'b000, 0, 0, 0);
    // key 0 press: key_state after 6 edges, outputs one edge later
    add(5, 0, 3'b110, 3'b000, 0, 0, 0);
    add(1, 0, 3'b110, 3'b001, 0, 0, 0);
    add(1, 0, 3'b110, 3'b001, 0, 1, 1);
    add(2, 0, 3'b110, 3'b001, 0, 1, 0);
    // release all
    add(5, 0, 3'b111, 3'b001, 0, 1, 0);
    add(1, 0, 3'b111, 3'b000, 0, 1, 0);
    add(2, 0, 3'b111, 3'b000, 0, 0, 0);
    // 3-cycle glitch on key 1: one short of the threshold
    add(3, 0, 3'b101, 3'b000, 0, 0, 0);
    add(6, 0, 3'b111, 3'b000, 0, 0, 0);
    // keys 0 and 1 together: one pulse, lowest index selected
    add(5, 0, 3'b100, 3'b000, 0, 0, 0);
    add(1, 0, 3'b100, 3'b011, 0, 0, 0);
    add(1, 0, 3'b100, 3'b011, 0, 1, 1);
    add(1, 0, 3'b100, 3'b011, 0, 1, 0);
    // release key 0 with key 1 held: tone moves, no pulse
    add(5, 0, 3'b101, 3'b011, 0, 1, 0);
    add(1, 0, 3'b101, 3'b010, 0, 1, 0);
    add(2, 0, 3'b101, 3'b010, 1, 1, 0);
    // release all: tone_sel keeps 1
    add(5, 0, 3'b111, 3'b010, 1, 1, 0);
    add(1, 0, 3'b111, 3'b000, 1, 1, 0);
    add(2, 0, 3'b111, 3'b000, 1, 0, 0);
    // key 2 press interrupted by rst: full count again afterwards
    add(3, 0, 3'b011, 3'b000, 1, 0, 0);
    add(1, 1, 3'b011, 3'b000, 0, 0, 0);
    add(5, 0, 3'b011, 3'b000, 0, 0, 0);
    add(1, 0, 3'b011, 3'b100, 0, 0, 0);
    add(1, 0, 3'b011, 3'b100, 2, 1, 1);
    add(1, 0, 3'b011, 3'b100, 2, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].ks, tbl[i].sel, tbl[i].en, tbl[i].kp);
    end

    // add keys 0 and 1 while key 2 is held: exactly one pulse
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 3'b000);
      if (key_press === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL multi_press_pulses: got %0d, want 1", pulses);
    end
    check("multi_press_final", 3'b111, 0, 1, 0);
`else
    // hold mode: tone persists across releases, moves on a new press
    step(1, 3'b111);
    step(1, 3'b111);
    check("hold_reset", 3'b000, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 3'b011);
    check("hold_press2", 3'b100, 2, 1, 1);
    step(0, 3'b011);
    check("hold_press2_after", 3'b100, 2, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 3'b111);
    check("hold_release", 3'b000, 2, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 3'b101);
    check("hold_press1", 3'b010, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 3'b111);
    check("hold_release1", 3'b000, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 3'b000);
    check("hold_multi", 3'b111, 0, 1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
